// File: rtl/alu_pkg.sv
// alu_pkg: shared operation codes, FSM states and sizing helper for the N-bit ALU
package alu_pkg;
    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_NOR = 5'b01100;
    localparam logic [4:0] ALU_MUL = 5'b10000;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    // Bits needed for a counter that must reach the value w itself
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational invert/operation datapath (AND, OR, add/sub, SLT, NOR)
module alu_core #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);
    logic [WIDTH-1:0] aa, bb;
    logic [WIDTH:0]   sum;

    // BInvert doubles as carry-in so that invert+add forms a two's complement subtract
    always_comb begin
        aa       = ctrl[3] ? ~a : a;
        bb       = ctrl[2] ? ~b : b;
        sum      = {1'b0, aa} + {1'b0, bb} + {{WIDTH{1'b0}}, ctrl[2]};
        carry    = sum[WIDTH];
        overflow = (aa[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != aa[WIDTH-1]);
        result   = ctrl[1:0] == 2'b00 ? aa & bb :
                   ctrl[1:0] == 2'b01 ? aa | bb :
                   ctrl[1:0] == 2'b10 ? sum[WIDTH-1:0] :
                   {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ overflow};
    end
endmodule

// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: registered N-bit ALU with start/valid handshake and shift-add multiplier
module alu_nbit_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [4:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             valid,
    output logic             busy,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);
    localparam int CW = cnt_width(WIDTH);

    state_t             state, next_state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [4:0]         op_ctrl;
    logic               pend;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     step;
    logic               accept, is_mul, done, single_legal, is_addsub;
    logic [WIDTH-1:0]   core_res;
    logic               core_carry, core_ovf;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a        (op_a),
        .b        (op_b),
        .ctrl     (op_ctrl[3:0]),
        .result   (core_res),
        .carry    (core_carry),
        .overflow (core_ovf)
    );

    // Handshake decode; the final MUL cycle already reports not-busy so the next op can be accepted
    always_comb begin
        done         = state == S_MUL && cnt == CW'(WIDTH);
        busy         = state == S_MUL && !done;
        accept       = start && !busy;
        is_mul       = MUL_EN && ctrl == ALU_MUL;
        single_legal = op_ctrl inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
        is_addsub    = op_ctrl == ALU_ADD || op_ctrl == ALU_SUB;
        step         = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, op_a & {WIDTH{acc[0]}}};
        next_state   = (accept && is_mul) ? S_MUL : (done ? S_IDLE : state);
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    // Operand capture and one shift-add iteration per busy cycle (multiplier lives in acc low half)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a    <= '0;
            op_b    <= '0;
            op_ctrl <= '0;
            pend    <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            pend <= accept && !is_mul;
            if (accept) begin
                op_a    <= a;
                op_b    <= b;
                op_ctrl <= ctrl;
            end
            if (accept && is_mul) begin
                acc <= {{WIDTH{1'b0}}, b};
                cnt <= '0;
            end else if (busy) begin
                acc <= {step, acc[WIDTH-1:1]};
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Result and flag registers, written one cycle after a single-cycle accept or when MUL completes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result    <= '0;
            result_hi <= '0;
            valid     <= 1'b0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (pend) begin
            result    <= single_legal ? core_res : '0;
            result_hi <= '0;
            valid     <= 1'b1;
            zero      <= single_legal && core_res == '0;
            carry     <= is_addsub && core_carry;
            overflow  <= (is_addsub || op_ctrl == ALU_SLT) && core_ovf;
            illegal   <= !single_legal;
        end else if (done) begin
            result    <= acc[WIDTH-1:0];
            result_hi <= acc[2*WIDTH-1:WIDTH];
            valid     <= 1'b1;
            zero      <= acc == '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            valid     <= 1'b0;
        end
    end
endmodule
